// File: rtl/u_atm_pkg.sv
// Shared types and constants for the ATM account-store arbiter and its front ends.
package u_atm_pkg;

  typedef enum logic [2:0] {
    OP_READ     = 3'd0,
    OP_DEBIT    = 3'd1,
    OP_CREDIT   = 3'd2,
    OP_TRANSFER = 3'd3,
    OP_SET_PASS = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_INSUFF    = 3'd1,
    ST_OVERFLOW  = 3'd2,
    ST_LIMIT     = 3'd3,
    ST_ZERO_AMT  = 3'd4,
    ST_SAME_ACCT = 3'd5,
    ST_BAD_OP    = 3'd6
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_A  = 4'd1,
    S_CHK_A = 4'd2,
    S_RD_B  = 4'd3,
    S_CHK_B = 4'd4,
    S_EXEC  = 4'd5,
    S_WR_A  = 4'd6,
    S_WR_B  = 4'd7,
    S_DONE  = 4'd8
  } arb_state_e;

  localparam int unsigned DEP_MAX = 5000;

endpackage

// File: rtl/u_rr_picker.sv
// Combinational round-robin selector: one-hot grant to the first request at or after ptr.
module u_rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/u_bank_arbiter.sv
// Round-robin arbiter sequencing atomic read-check-write transactions on the
// single-port account store shared by the ATM front-end FSMs.
module u_bank_arbiter #(
  parameter int unsigned NREQ          = 2,
  parameter int unsigned CIS           = 4,
  parameter int unsigned balance_width = 14,
  parameter int unsigned Pass_width    = 16,
  parameter int unsigned DEP_MAX       = u_atm_pkg::DEP_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*3-1:0]          req_op,
  input  logic [NREQ*CIS-1:0]        req_src,
  input  logic [NREQ*CIS-1:0]        req_dst,
  input  logic [NREQ*16-1:0]         req_amount,
  input  logic [NREQ*Pass_width-1:0] req_pass,
  output logic [NREQ-1:0]            ack,
  output logic [2:0]                 rsp_status,
  output logic [balance_width-1:0]   rsp_balance,
  output logic [Pass_width-1:0]      rsp_pass,
  output logic                       busy,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [CIS-1:0]             mem_addr,
  output logic [balance_width-1:0]   mem_wbal,
  output logic [Pass_width-1:0]      mem_wpass,
  input  logic [balance_width-1:0]   mem_rbal,
  input  logic [Pass_width-1:0]      mem_rpass
);

  import u_atm_pkg::*;

  localparam int unsigned PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [16:0] BAL_MAX17 = 17'((2 ** balance_width) - 1);
  localparam logic [16:0] DEP_MAX17 = 17'(DEP_MAX);

  arb_state_e state_q, state_d;

  logic [NREQ-1:0]          pick_gnt;
  logic                     pick_valid;
  logic [PW-1:0]            pick_idx;
  logic [PW-1:0]            ptr_q, gnt_q;
  logic [2:0]               op_q;
  logic [CIS-1:0]           src_q, dst_q;
  logic [15:0]              amount_q;
  logic [Pass_width-1:0]    pass_q, pass_a_q, pass_b_q;
  logic [balance_width-1:0] bal_a_q, bal_b_q;

  logic [16:0]              amt17, bal_a17, bal_b17, sum_a, sum_b, diff_a;
  status_e                  st_c;
  logic [balance_width-1:0] nb_a, nb_b;
  logic                     wr_op;

  u_rr_picker #(.N(NREQ), .PW(PW)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (pick_gnt[i]) pick_idx = PW'(i);
  end

  // Status and new balances depend only on latched fields, so they stay valid
  // from EXEC through the write states and into the DONE capture.
  always_comb begin
    amt17   = 17'(amount_q);
    bal_a17 = 17'(bal_a_q);
    bal_b17 = 17'(bal_b_q);
    sum_a   = bal_a17 + amt17;
    sum_b   = bal_b17 + amt17;
    diff_a  = bal_a17 - amt17;
    wr_op   = (op_q == OP_DEBIT) || (op_q == OP_CREDIT) ||
              (op_q == OP_TRANSFER) || (op_q == OP_SET_PASS);

    st_c = ST_OK;
    if (op_q > 3'd4)
      st_c = ST_BAD_OP;
    else if (op_q == OP_TRANSFER && src_q == dst_q)
      st_c = ST_SAME_ACCT;
    else if ((op_q == OP_DEBIT || op_q == OP_CREDIT || op_q == OP_TRANSFER) && amount_q == '0)
      st_c = ST_ZERO_AMT;
    else if ((op_q == OP_CREDIT || op_q == OP_TRANSFER) && amt17 > DEP_MAX17)
      st_c = ST_LIMIT;
    else if ((op_q == OP_DEBIT || op_q == OP_TRANSFER) && amt17 > bal_a17)
      st_c = ST_INSUFF;
    else if (op_q == OP_CREDIT && sum_a > BAL_MAX17)
      st_c = ST_OVERFLOW;
    else if (op_q == OP_TRANSFER && sum_b > BAL_MAX17)
      st_c = ST_OVERFLOW;

    nb_a = bal_a_q;
    nb_b = bal_b_q;
    if (op_q == OP_DEBIT || op_q == OP_TRANSFER) nb_a = diff_a[balance_width-1:0];
    if (op_q == OP_CREDIT)                       nb_a = sum_a[balance_width-1:0];
    if (op_q == OP_TRANSFER)                     nb_b = sum_b[balance_width-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_RD_A;
      S_RD_A:  state_d = S_CHK_A;
      S_CHK_A: state_d = (op_q == OP_TRANSFER) ? S_RD_B : S_EXEC;
      S_RD_B:  state_d = S_CHK_B;
      S_CHK_B: state_d = S_EXEC;
      S_EXEC:  state_d = (st_c == ST_OK && wr_op) ? S_WR_A : S_DONE;
      S_WR_A:  state_d = (op_q == OP_TRANSFER) ? S_WR_B : S_DONE;
      S_WR_B:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      op_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      amount_q    <= '0;
      pass_q      <= '0;
      pass_a_q    <= '0;
      pass_b_q    <= '0;
      bal_a_q     <= '0;
      bal_b_q     <= '0;
      rsp_status  <= '0;
      rsp_balance <= '0;
      rsp_pass    <= '0;
    end else begin
      if (state_q == S_IDLE && pick_valid) begin
        gnt_q    <= pick_idx;
        op_q     <= req_op[32'(pick_idx)*3 +: 3];
        src_q    <= req_src[32'(pick_idx)*CIS +: CIS];
        dst_q    <= req_dst[32'(pick_idx)*CIS +: CIS];
        amount_q <= req_amount[32'(pick_idx)*16 +: 16];
        pass_q   <= req_pass[32'(pick_idx)*Pass_width +: Pass_width];
      end
      if (state_q == S_CHK_A) begin
        bal_a_q  <= mem_rbal;
        pass_a_q <= mem_rpass;
      end
      if (state_q == S_CHK_B) begin
        bal_b_q  <= mem_rbal;
        pass_b_q <= mem_rpass;
      end
      if (state_d == S_DONE && state_q != S_DONE) begin
        rsp_status  <= st_c;
        rsp_balance <= (st_c == ST_OK) ? nb_a : bal_a_q;
        rsp_pass    <= (st_c == ST_OK && op_q == OP_SET_PASS) ? pass_q : pass_a_q;
        ptr_q       <= (32'(gnt_q) == NREQ - 1) ? '0 : gnt_q + PW'(1);
      end
    end
  end

  // Store strobes are gated by rst so a reset landing on a write cycle never commits.
  always_comb begin
    ack       = '0;
    busy      = (state_q != S_IDLE);
    mem_en    = !rst && (state_q == S_RD_A || state_q == S_RD_B ||
                         state_q == S_WR_A || state_q == S_WR_B);
    mem_we    = !rst && (state_q == S_WR_A || state_q == S_WR_B);
    mem_addr  = (state_q == S_RD_B || state_q == S_WR_B) ? dst_q : src_q;
    mem_wbal  = (state_q == S_WR_B) ? nb_b : nb_a;
    mem_wpass = (state_q == S_WR_B) ? pass_b_q :
                (op_q == OP_SET_PASS) ? pass_q : pass_a_q;
    if (state_q == S_DONE) ack[gnt_q] = 1'b1;
  end

endmodule

// File: tb/tb_u_bank_arbiter.sv
// Directed bench for u_bank_arbiter with a behavioural single-port account store.
module tb_u_bank_arbiter;

  localparam int NREQ = 2;
  localparam int CIS  = 4;
  localparam int BW   = 14;
  localparam int PWD  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ*CIS-1:0]   req_src, req_dst;
  logic [NREQ*16-1:0]    req_amount;
  logic [NREQ*PWD-1:0]   req_pass;
  logic [NREQ-1:0]       ack;
  logic [2:0]            rsp_status;
  logic [BW-1:0]         rsp_balance;
  logic [PWD-1:0]        rsp_pass;
  logic                  busy, mem_en, mem_we;
  logic [CIS-1:0]        mem_addr;
  logic [BW-1:0]         mem_wbal, mem_rbal;
  logic [PWD-1:0]        mem_wpass, mem_rpass;

  logic [BW-1:0]  mbal  [16];
  logic [PWD-1:0] mpass [16];
  logic           ld_en;
  logic [CIS-1:0] ld_addr;
  logic [BW-1:0]  ld_bal;
  logic [PWD-1:0] ld_pass;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  u_bank_arbiter #(
    .NREQ(NREQ), .CIS(CIS), .balance_width(BW), .Pass_width(PWD), .DEP_MAX(5000)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_src(req_src),
    .req_dst(req_dst), .req_amount(req_amount), .req_pass(req_pass),
    .ack(ack), .rsp_status(rsp_status), .rsp_balance(rsp_balance),
    .rsp_pass(rsp_pass), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wbal(mem_wbal), .mem_wpass(mem_wpass),
    .mem_rbal(mem_rbal), .mem_rpass(mem_rpass)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      mbal[ld_addr]  <= ld_bal;
      mpass[ld_addr] <= ld_pass;
    end else if (mem_en && mem_we) begin
      mbal[mem_addr]  <= mem_wbal;
      mpass[mem_addr] <= mem_wpass;
    end else if (mem_en) begin
      mem_rbal  <= mbal[mem_addr];
      mem_rpass <= mpass[mem_addr];
    end
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input int b, input int p);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = CIS'(a); ld_bal = BW'(b); ld_pass = PWD'(p);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic txn(input string tag, input int who, input int op, input int src,
                     input int dst, input int amt, input int np, input int exp_st,
                     input int exp_bal, input int exp_lat, input int exp_wr);
    int  lat, wr;
    bit  got_ack;
    @(negedge clk);
    req_op[who*3 +: 3]         = 3'(op);
    req_src[who*CIS +: CIS]    = CIS'(src);
    req_dst[who*CIS +: CIS]    = CIS'(dst);
    req_amount[who*16 +: 16]   = 16'(amt);
    req_pass[who*PWD +: PWD]   = PWD'(np);
    req[who]                   = 1'b1;
    lat = 0; wr = 0; got_ack = 1'b0;
    for (int c = 0; c < 40 && !got_ack; c++) begin
      @(negedge clk);
      if (mem_en && mem_we) wr++;
      if (ack != '0) begin
        got_ack = 1'b1;
        chk({tag, " ack"}, ack, 1 << who);
      end else if (busy) lat++;
    end
    req[who] = 1'b0;
    chk({tag, " acked"}, got_ack, 1);
    chk({tag, " status"}, rsp_status, exp_st);
    chk({tag, " balance"}, rsp_balance, exp_bal);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " writes"}, wr, exp_wr);
  endtask

  initial begin
    int k, busy_cnt;
    int unsigned seq [4];
    rst = 1'b1; req = '0; req_op = '0; req_src = '0; req_dst = '0;
    req_amount = '0; req_pass = '0; ld_en = 1'b0; ld_addr = '0; ld_bal = '0; ld_pass = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ack", ack, 0);
    chk("rst busy", busy, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst status", rsp_status, 0);
    chk("rst balance", rsp_balance, 0);
    chk("rst pass", rsp_pass, 0);

    preload(3, 1000, 'h1234);
    txn("debit ok", 0, 1, 3, 0, 300, 0, 0, 700, 4, 1);
    chk("debit store bal", mbal[3], 700);
    chk("debit store pass", mpass[3], 'h1234);
    txn("debit insuff", 0, 1, 3, 0, 701, 0, 1, 700, 3, 0);
    chk("insuff store", mbal[3], 700);

    preload(1, 16000, 'h1111);
    preload(2, 500, 'h2222);
    txn("xfer ovf", 0, 3, 2, 1, 400, 0, 2, 500, 5, 0);
    chk("xfer ovf s1", mbal[1], 16000);
    chk("xfer ovf s2", mbal[2], 500);
    txn("xfer ok", 0, 3, 1, 2, 400, 0, 0, 15600, 7, 2);
    chk("xfer ok s1", mbal[1], 15600);
    chk("xfer ok s2", mbal[2], 900);
    chk("xfer ok p2", mpass[2], 'h2222);

    preload(4, 100, 'h4444);
    txn("credit limit", 0, 2, 4, 0, 5001, 0, 3, 100, 3, 0);
    txn("credit zero", 0, 2, 4, 0, 0, 0, 4, 100, 3, 0);
    txn("bad op", 0, 7, 4, 0, 10, 0, 6, 100, 3, 0);
    chk("bad op store", mbal[4], 100);
    txn("credit max", 0, 2, 4, 0, 5000, 0, 0, 5100, 4, 1);
    txn("set pass", 1, 4, 4, 0, 0, 'hBEEF, 0, 5100, 4, 1);
    chk("set pass rsp", rsp_pass, 'hBEEF);
    chk("set pass store", mpass[4], 'hBEEF);
    chk("set pass bal", mbal[4], 5100);
    txn("same acct", 0, 3, 2, 2, 1, 0, 5, 900, 5, 0);
    txn("read", 1, 0, 1, 0, 0, 0, 0, 15600, 3, 0);
    chk("read pass", rsp_pass, 'h1111);
    txn("debit exact", 0, 1, 4, 0, 5100, 0, 0, 0, 4, 1);
    chk("debit exact store", mbal[4], 0);
    txn("credit ovf", 0, 2, 1, 0, 784, 0, 2, 15600, 3, 0);
    txn("credit to max", 0, 2, 1, 0, 783, 0, 0, 16383, 4, 1);

    // Fresh reset puts the round-robin pointer back at 0.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req_op = {3'd0, 3'd0}; req_src = {4'd2, 4'd3}; req = 2'b11;
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(negedge clk);
      if (ack != '0) begin seq[k] = ack; k++; end
    end
    req = '0;
    chk("arb count", k, 4);
    chk("arb 1st", seq[0], 1);
    chk("arb 2nd", seq[1], 2);
    chk("arb 3rd", seq[2], 1);
    chk("arb 4th", seq[3], 2);

    preload(5, 200, 'h55);
    @(negedge clk);
    req_op[2:0] = 3'd1; req_src[3:0] = 4'd5; req_amount[15:0] = 16'd50; req[0] = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 40 && busy_cnt < 4; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("wr_a reached", busy_cnt, 4);
    rst = 1'b1;
    #1;
    chk("rst gates we", mem_we, 0);
    @(negedge clk);
    chk("post rst busy", busy, 0);
    chk("post rst ack", ack, 0);
    rst = 1'b0; req = '0;
    repeat (3) @(negedge clk);
    chk("post rst store", mbal[5], 200);
    chk("post rst idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/u_bank_arbiter.md
Name: u_bank_arbiter

Overview:
- Sequences and shares the single-port account store (per-card balance and password) between NREQ ATM front-end FSMs.
- Accepts one transaction at a time: read, debit, credit, transfer or password change.
- Selects requesters round-robin and performs an atomic read-check-write sequence on the store.
- Returns a one-cycle acknowledge carrying a status code and the resulting balance.

Parameters:
- NREQ, 2, number of requesting ATM FSMs.
- CIS, 4, account index width (store depth 2^CIS).
- balance_width, 14, unsigned balance width; BAL_MAX = 2^balance_width-1.
- Pass_width, 16, password width.
- DEP_MAX, 5000, maximum single credit or transfer amount.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; level, held until ack
- req_op  in  NREQ*3  opcode per requester: 0 READ, 1 DEBIT, 2 CREDIT, 3 TRANSFER, 4 SET_PASS
- req_src  in  NREQ*CIS  source account index
- req_dst  in  NREQ*CIS  destination index (TRANSFER only)
- req_amount  in  NREQ*16  amount
- req_pass  in  NREQ*Pass_width  new password (SET_PASS only)
- ack  out  NREQ  one-hot, one-cycle completion pulse
- rsp_status  out  3  0 OK, 1 INSUFF, 2 OVERFLOW, 3 LIMIT, 4 ZERO_AMT, 5 SAME_ACCT, 6 BAD_OP
- rsp_balance  out  balance_width  source balance after the operation
- rsp_pass  out  Pass_width  source password as stored after the operation
- busy  out  1  high in every state except IDLE
- mem_en  out  1  store access strobe
- mem_we  out  1  write enable (1 = write)
- mem_addr  out  CIS  store index
- mem_wbal  out  balance_width  write balance
- mem_wpass  out  Pass_width  write password
- mem_rbal  in  balance_width  read balance, valid the cycle after a read strobe
- mem_rpass  in  Pass_width  read password, same timing as mem_rbal

Behaviour:
- Reset (sync, active-high):
  - Registers: state IDLE, rr pointer 0, latched fields 0.
  - Outputs: ack, mem_en, mem_we and busy 0; rsp_* 0.
  - mem_en and mem_we are gated by rst, so no store write occurs at an edge where rst=1, even mid-WR_A or WR_B.
- Outputs are decoded from registered state and latched fields only. No combinational path from req to any output.
- Arbitration (IDLE only):
  - Winner is the first asserted req at or after the rr pointer, wrapping.
  - Latch gnt, op, src, dst, amount and pass. Next state RD_A.
  - rr pointer becomes gnt+1 (mod NREQ) when DONE is entered.
  - No req asserted: stay in IDLE.
- States:
  - IDLE: arbitrate as above.
  - RD_A: mem_en=1, mem_we=0, addr=src. Next CHK_A.
  - CHK_A: capture bal_a and pass_a. TRANSFER goes to RD_B; every other op goes to EXEC.
  - RD_B: read dst. Next CHK_B.
  - CHK_B: capture bal_b. Next EXEC.
  - EXEC: compute status. OK with a writing op goes to WR_A; otherwise DONE.
  - WR_A: write src (new balance, pass_a or the new password). TRANSFER goes to WR_B; otherwise DONE.
  - WR_B: write dst with new bal_b and the unchanged read password. Next DONE.
  - DONE: ack[gnt]=1 for one cycle. Next IDLE.
- Status checks, evaluated in this priority order:
  - op > 4 gives BAD_OP.
  - TRANSFER with src==dst gives SAME_ACCT.
  - amount==0 on DEBIT, CREDIT or TRANSFER gives ZERO_AMT.
  - CREDIT or TRANSFER with amount > DEP_MAX gives LIMIT.
  - DEBIT or TRANSFER with amount > bal_a gives INSUFF.
  - CREDIT with bal_a+amount > BAL_MAX gives OVERFLOW; TRANSFER with bal_b+amount > BAL_MAX gives OVERFLOW.
  - Otherwise OK.
  - READ always returns OK. SET_PASS always returns OK.
- Arithmetic: comparisons and sums are computed in 17 bits, zero-extended; a stored result never wraps.
- Atomicity: a TRANSFER writes both accounts or neither, because all checks finish before WR_A.
- Latency from the grant cycle (IDLE) to the ack cycle:
  - 3 cycles: READ, and any non-OK result on a single-read op.
  - 4 cycles: DEBIT, CREDIT or SET_PASS with OK.
  - 7 cycles: TRANSFER with OK.
  - 5 cycles: failed TRANSFER that reached CHK_B. BAD_OP, SAME_ACCT and ZERO_AMT on a TRANSFER are still decided only in EXEC, after RD_B/CHK_B.
- Handshake: the requester holds req and its fields stable until it sees ack. It deasserts req at the edge that samples ack, so the following IDLE never re-grants a stale request.
- req dropped before ack is a protocol violation. The latched transaction still completes and is acked.
- rsp_balance, rsp_status and rsp_pass are stable from DONE until the next DONE.

Decomposition:
- Shared package u_atm_pkg holds:
  - opcode enum (READ..SET_PASS);
  - status enum (OK..BAD_OP);
  - arbiter state enum;
  - DEP_MAX constant.
- Sub-module u_rr_picker: combinational round-robin one-hot selector (req, ptr → gnt, valid), reusable by other arbiters.

Test Plan:
- Store[3]=1000; req0 DEBIT src=3 amount=300 → ack[0] at grant+4; status OK; rsp_balance=700; store[3]=700.
- Store[3]=700; req0 DEBIT amount=701 → ack at grant+3; status INSUFF; no mem_we pulse; store unchanged.
- Store[1]=16000, store[2]=500; TRANSFER src=2 dst=1 amount=400 → status OVERFLOW; neither account written. Then TRANSFER src=1 dst=2 amount=400 → OK; store[1]=15600, store[2]=900; ack at grant+7.
- req0 and req1 asserted together with rr=0 → req0 served first, then req1. With both requests held continuously, grants alternate 0,1,0,1.
- CREDIT amount=5001 → LIMIT. CREDIT amount=0 → ZERO_AMT. op=7 → BAD_OP. No store write in any of the three.
- Assert rst in the WR_A cycle of a DEBIT → no write, target account unchanged; next cycle state IDLE, ack=0, busy=0.
